// File: rtl/dsp_pkg.sv
// Shared constants and mux-select encodings for the dsp slice.
package dsp_pkg;

  localparam int unsigned DataW = 18;
  localparam int unsigned MultW = 36;
  localparam int unsigned AccW  = 48;

  // OPMODE bit positions
  localparam int unsigned OpXLo      = 0;
  localparam int unsigned OpZLo      = 2;
  localparam int unsigned OpPreAdd   = 4;
  localparam int unsigned OpCarryIn  = 5;
  localparam int unsigned OpPreSub   = 6;
  localparam int unsigned OpPostSub  = 7;

  typedef enum logic [1:0] {
    XZero   = 2'd0,
    XMult   = 2'd1,
    XP      = 2'd2,
    XConcat = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    ZZero = 2'd0,
    ZPcin = 2'd1,
    ZP    = 2'd2,
    ZC    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: clock-enabled with async clear, or a plain wire when disabled.
module dsp_pipe_reg #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned EN_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (EN_REG != 0) begin : g_reg
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_q <= '0;
      end else if (ce) begin
        q_q <= d;
      end
    end
    assign q = q_q;
  end else begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, ce};
    assign q = d;
  end

endmodule

// File: rtl/dsp.sv
// Pre-adder / multiplier / post-adder slice with individually optional pipeline registers.
module dsp
  import dsp_pkg::*;
#(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter string       B_INPUT     = "DIRECT"
) (
  input  logic [DataW-1:0] A,
  input  logic [DataW-1:0] B,
  input  logic [DataW-1:0] D,
  input  logic [AccW-1:0]  C,
  output logic [MultW-1:0] M,
  input  logic [DataW-1:0] BCIN,
  input  logic             CARRYIN,
  output logic [AccW-1:0]  P,
  output logic             CARRYOUT,
  output logic             CARRYOUTF,
  input  logic             CEA,
  input  logic             CEB,
  input  logic             CEC,
  input  logic             CECARRYIN,
  input  logic             CED,
  input  logic             CEM,
  input  logic             CEOPMODE,
  input  logic             CEP,
  input  logic             RSTA,
  input  logic             RSTB,
  input  logic             RSTC,
  input  logic             RSTCARRYIN,
  input  logic             RSTD,
  input  logic             RSTM,
  input  logic             RSTOPMODE,
  input  logic             RSTP,
  output logic [DataW-1:0] BCOUT,
  output logic [AccW-1:0]  PCOUT,
  input  logic [AccW-1:0]  PCIN,
  input  logic             CLK,
  input  logic [7:0]       OPMODE
);

  logic [DataW-1:0] b_sel, d_q, a0_q, b0_q, a1_q, b1_q, pre_add_d;
  logic [AccW-1:0]  c_q, x_mux, z_mux, p_d, p_q;
  logic [MultW-1:0] m_d, m_q;
  logic [7:0]       op_q;
  logic             cyi_d, cyi_q, cyo_d, cyo_q;
  logic [AccW:0]    post_sum;

  assign b_sel = (B_INPUT == "CASCADE") ? BCIN : B;

  // Stage 0
  dsp_pipe_reg #(.WIDTH(DataW), .EN_REG(DREG)) u_d_reg (
    .clk(CLK), .rst(RSTD), .ce(CED), .d(D), .q(d_q)
  );
  dsp_pipe_reg #(.WIDTH(DataW), .EN_REG(A0REG)) u_a0_reg (
    .clk(CLK), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q)
  );
  dsp_pipe_reg #(.WIDTH(DataW), .EN_REG(B0REG)) u_b0_reg (
    .clk(CLK), .rst(RSTB), .ce(CEB), .d(b_sel), .q(b0_q)
  );
  dsp_pipe_reg #(.WIDTH(AccW), .EN_REG(CREG)) u_c_reg (
    .clk(CLK), .rst(RSTC), .ce(CEC), .d(C), .q(c_q)
  );
  dsp_pipe_reg #(.WIDTH(8), .EN_REG(OPMODEREG)) u_op_reg (
    .clk(CLK), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op_q)
  );

  always_comb begin
    pre_add_d = b0_q;
    if (op_q[OpPreAdd]) begin
      pre_add_d = op_q[OpPreSub] ? (d_q - b0_q) : (d_q + b0_q);
    end
  end

  // Stage 1
  dsp_pipe_reg #(.WIDTH(DataW), .EN_REG(B1REG)) u_b1_reg (
    .clk(CLK), .rst(RSTB), .ce(CEB), .d(pre_add_d), .q(b1_q)
  );
  dsp_pipe_reg #(.WIDTH(DataW), .EN_REG(A1REG)) u_a1_reg (
    .clk(CLK), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q)
  );

  assign m_d = MultW'(b1_q) * MultW'(a1_q);

  dsp_pipe_reg #(.WIDTH(MultW), .EN_REG(MREG)) u_m_reg (
    .clk(CLK), .rst(RSTM), .ce(CEM), .d(m_d), .q(m_q)
  );

  assign cyi_d = (CARRYINSEL == "CARRYIN") ? CARRYIN : op_q[OpCarryIn];

  dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYINREG)) u_cyi_reg (
    .clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_d), .q(cyi_q)
  );

  always_comb begin
    x_mux = '0;
    unique case (x_sel_e'(op_q[OpXLo +: 2]))
      XZero:   x_mux = '0;
      XMult:   x_mux = AccW'(m_q);
      XP:      x_mux = p_q;
      XConcat: x_mux = {d_q[11:0], a1_q, b1_q};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    unique case (z_sel_e'(op_q[OpZLo +: 2]))
      ZZero:   z_mux = '0;
      ZPcin:   z_mux = PCIN;
      ZP:      z_mux = p_q;
      ZC:      z_mux = c_q;
      default: z_mux = '0;
    endcase
  end

  // Bit 48 is the carry on add and the borrow on subtract.
  always_comb begin
    if (op_q[OpPostSub]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + (AccW + 1)'(cyi_q));
    end else begin
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + (AccW + 1)'(cyi_q);
    end
  end

  assign p_d   = post_sum[AccW-1:0];
  assign cyo_d = post_sum[AccW];

  dsp_pipe_reg #(.WIDTH(AccW), .EN_REG(PREG)) u_p_reg (
    .clk(CLK), .rst(RSTP), .ce(CEP), .d(p_d), .q(p_q)
  );
  dsp_pipe_reg #(.WIDTH(1), .EN_REG(CARRYOUTREG)) u_cyo_reg (
    .clk(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyo_d), .q(cyo_q)
  );

  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = b1_q;
  assign CARRYOUT  = cyo_q;
  assign CARRYOUTF = cyo_q;

endmodule

// File: tb/tb_dsp.sv
// Directed and randomized checks of dsp against an arithmetic reference model.
module tb_dsp;

  logic [17:0] A, B, D, BCIN, BCOUT;
  logic [47:0] C, P, PCIN, PCOUT;
  logic [35:0] M;
  logic        CARRYIN, CARRYOUT, CARRYOUTF;
  logic        CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP;
  logic        RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP;
  logic        CLK = 1'b0;
  logic [7:0]  OPMODE;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  dsp u_dut (
    .A(A), .B(B), .D(D), .C(C), .M(M), .BCIN(BCIN), .CARRYIN(CARRYIN), .P(P),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CECARRYIN(CECARRYIN), .CED(CED), .CEM(CEM),
    .CEOPMODE(CEOPMODE), .CEP(CEP),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTCARRYIN(RSTCARRYIN), .RSTD(RSTD),
    .RSTM(RSTM), .RSTOPMODE(RSTOPMODE), .RSTP(RSTP),
    .BCOUT(BCOUT), .PCOUT(PCOUT), .PCIN(PCIN), .CLK(CLK), .OPMODE(OPMODE)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Steady-state behaviour of one P update with all upstream stages settled on these inputs.
  task automatic model(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic [47:0] c, input logic [47:0] pcin, input logic [7:0] op,
                       input logic [47:0] p_in, output logic [17:0] bc,
                       output logic [35:0] m, output logic [47:0] p_out, output logic co);
    int             pre;
    longint         x, z, cin, res;
    logic [63:0]    res_bits;
    if (!op[4])     pre = int'(b);
    else if (op[6]) pre = int'(d) - int'(b);
    else            pre = int'(d) + int'(b);
    pre = pre % 262144;
    if (pre < 0) pre += 262144;
    bc = 18'(pre);
    m  = 36'(longint'(pre) * longint'(a));
    case (op[1:0])
      2'd0:    x = 0;
      2'd1:    x = longint'(m);
      2'd2:    x = longint'(p_in);
      default: x = (longint'(d[11:0]) << 36) + (longint'(a) << 18) + longint'(pre);
    endcase
    case (op[3:2])
      2'd0:    z = 0;
      2'd1:    z = longint'(pcin);
      2'd2:    z = longint'(p_in);
      default: z = longint'(c);
    endcase
    cin = longint'(op[5]);
    if (op[7]) begin
      res = z - x - cin;
      co  = (res < 0);
    end else begin
      res = z + x + cin;
      co  = (res >= (64'd1 << 48));
    end
    res_bits = 64'(res);
    p_out    = res_bits[47:0];
  endtask

  logic [47:0] p_model, p_next;
  logic [35:0] m_exp;
  logic [17:0] bc_exp;
  logic        co_exp;

  initial begin
    {A, B, D, BCIN, C, PCIN, CARRYIN, OPMODE} = '0;
    {CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP} = '1;
    {RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP} = '1;
    A = 18'd77; B = 18'd33; D = 18'd5; C = 48'd9; PCIN = 48'd12; OPMODE = 8'hFF;
    step(2);
    check_eq("rst_p", P, 0);
    check_eq("rst_m", M, 0);
    check_eq("rst_bcout", BCOUT, 0);
    check_eq("rst_pcout", PCOUT, 0);
    check_eq("rst_carryout", CARRYOUT, 0);
    check_eq("rst_carryoutf", CARRYOUTF, 0);
    {A, B, D, C, PCIN, OPMODE} = '0;
    {RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP} = '0;
    step(1);

    // Pre-adder add then subtract, two edges to BCOUT
    D = 18'd10; B = 18'd10; OPMODE = 8'h10;
    step(2);
    check_eq("preadd_add", BCOUT, 20);
    D = 18'd30; B = 18'd20; OPMODE = 8'h50;
    step(2);
    check_eq("preadd_sub", BCOUT, 10);

    // Multiply, three edges to M
    A = 18'd10; B = 18'd5; D = 18'd10; OPMODE = 8'h10;
    step(3);
    check_eq("mult_m", M, 150);
    check_eq("mult_bcout", BCOUT, 15);

    PCIN = 48'd100; OPMODE = 8'h15;
    step(4);
    check_eq("p_pcin_add", P, 250);
    check_eq("pcout_pcin_add", PCOUT, 250);
    OPMODE = 8'h35;
    step(4);
    check_eq("p_carryin", P, 251);
    check_eq("co_carryin", CARRYOUT, 0);

    C = 48'd2; OPMODE = 8'h1D;
    step(4);
    check_eq("p_c_add", P, 152);
    C = 48'd200; OPMODE = 8'h9D;
    step(4);
    check_eq("p_c_sub", P, 50);
    PCIN = 48'd500; OPMODE = 8'h95;
    step(4);
    check_eq("p_pcin_sub", P, 350);

    OPMODE = 8'h91;
    step(4);
    check_eq("p_underflow", P, (64'd1 << 48) - 64'd150);
    check_eq("co_underflow", CARRYOUT, 1);
    check_eq("cof_underflow", CARRYOUTF, 1);

    #2 RSTP = 1'b1;
    #1;
    check_eq("p_async_rst", P, 0);
    check_eq("pcout_async_rst", PCOUT, 0);
    check_eq("co_after_rstp", CARRYOUT, 1);
    RSTM = 1'b1;
    #1;
    check_eq("m_async_rst", M, 0);
    RSTM = 1'b0;
    RSTP = 1'b0;
    step(1);
    check_eq("m_refill", M, 150);
    p_model = '0;

    // Random transactions: settle upstream with P frozen, then release P for a few edges
    for (int t = 0; t < 40; t++) begin
      logic [17:0] ra, rb, rd;
      logic [47:0] rc, rpcin;
      logic [7:0]  rop;
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)};
      rpcin = {16'($urandom), 32'($urandom)};
      rop = 8'($urandom);
      if (t % 5 == 0) begin
        ra = '1; rb = '1; rd = '1; rc = '1;
      end
      CEP = 1'b0;
      A = ra; B = rb; D = rd; C = rc; PCIN = rpcin; OPMODE = rop;
      BCIN = 18'($urandom); CARRYIN = 1'($urandom);
      step(4);
      model(ra, rb, rd, rc, rpcin, rop, p_model, bc_exp, m_exp, p_next, co_exp);
      check_eq($sformatf("rnd%0d_bcout", t), BCOUT, bc_exp);
      check_eq($sformatf("rnd%0d_m", t), M, m_exp);
      check_eq($sformatf("rnd%0d_p_hold", t), P, p_model);
      CEP = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step(1);
        model(ra, rb, rd, rc, rpcin, rop, p_model, bc_exp, m_exp, p_next, co_exp);
        p_model = p_next;
        check_eq($sformatf("rnd%0d_p%0d op=%0h", t, k, rop), P, p_model);
        check_eq($sformatf("rnd%0d_co%0d op=%0h", t, k, rop), CARRYOUT, co_exp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
